eth_rx_hdr_filter: RTL and testbench

//  Consumes the 8-bit rx_axis stream leaving the MII MAC RX FIFO (logic_clk domain). Parses the
//  14-byte Ethernet header and filters on destination MAC and, optionally, EtherType. Accepted

---
 rtl/eth_rx_hdr_filter.sv | 159 +++++++++++++++
 tb/tb_eth_rx_hdr_filter.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_rx_hdr_filter.sv
// Ethernet receive header filter.
// Parses the 14-byte Ethernet header from the RX FIFO byte stream, decides on
// destination MAC (and optionally EtherType) whether the frame is wanted, and
// either presents the header and passes the payload straight through, or
// swallows the rest of the frame. Feeds the IP/UDP receive path.
module eth_rx_hdr_filter #(
  parameter bit          ACCEPT_BROADCAST = 1'b1,
  parameter bit          ACCEPT_MULTICAST = 1'b0,
  parameter bit          ETYPE_FILTER_EN  = 1'b0,
  parameter logic [15:0] ETYPE_MATCH      = 16'h0800
) (
  input  logic        logic_clk,
  input  logic        logic_rst_n,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic        s_axis_tlast,
  input  logic        s_axis_tuser,
  output logic        m_eth_hdr_valid,
  input  logic        m_eth_hdr_ready,
  output logic [47:0] m_eth_dest_mac,
  output logic [47:0] m_eth_src_mac,
  output logic [15:0] m_eth_type,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic        m_axis_tuser,
  input  logic [47:0] local_mac,
  input  logic        promisc_en,
  output logic        stat_accepted,
  output logic        stat_filtered,
  output logic        stat_runt
);

  typedef enum logic [1:0] {
    HDR,
    HDR_OUT,
    PAYLOAD,
    DROP
  } state_e;

  state_e        state_q;
  logic [3:0]    cnt_q;
  logic [111:0]  hdr_q;
  logic          hdrValid_q;
  logic          statAccepted_q;
  logic          statFiltered_q;
  logic          statRunt_q;

  logic          inBeat;
  logic [47:0]   liveDest;
  logic [15:0]   liveType;
  logic          destMatch;
  logic          typeMatch;
  logic          hdrMatch;

  // Accept/reject decision, taken while header byte 13 is still on the bus:
  // the EtherType low byte comes live from the input, everything else is registered.
  always_comb begin
    inBeat    = s_axis_tvalid & s_axis_tready;
    liveDest  = hdr_q[111:64];
    liveType  = {hdr_q[15:8], s_axis_tdata};
    destMatch = promisc_en
              | (liveDest == local_mac)
              | (ACCEPT_BROADCAST && (liveDest == 48'hFFFF_FFFF_FFFF))
              | (ACCEPT_MULTICAST && liveDest[40]);
    typeMatch = !ETYPE_FILTER_EN || (liveType == ETYPE_MATCH);
    hdrMatch  = destMatch & typeMatch;
  end

  // Input ready and payload pass-through; the payload path is purely combinational
  // so no byte is ever buffered here.
  always_comb begin
    s_axis_tready = 1'b0;
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = 8'h00;
    m_axis_tlast  = 1'b0;
    m_axis_tuser  = 1'b0;
    unique case (state_q)
      HDR, DROP: s_axis_tready = 1'b1;
      PAYLOAD: begin
        s_axis_tready = m_axis_tready;
        m_axis_tvalid = s_axis_tvalid;
        m_axis_tdata  = s_axis_tdata;
        m_axis_tlast  = s_axis_tlast;
        m_axis_tuser  = s_axis_tuser & s_axis_tlast;
      end
      default: ;
    endcase
  end

  // Frame FSM: header capture, filter decision, header handshake, payload/drop tracking.
  always_ff @(posedge logic_clk or negedge logic_rst_n) begin
    if (!logic_rst_n) begin
      state_q        <= HDR;
      cnt_q          <= 4'd0;
      hdr_q          <= '0;
      hdrValid_q     <= 1'b0;
      statAccepted_q <= 1'b0;
      statFiltered_q <= 1'b0;
      statRunt_q     <= 1'b0;
    end else begin
      statAccepted_q <= 1'b0;
      statFiltered_q <= 1'b0;
      statRunt_q     <= 1'b0;
      unique case (state_q)
        HDR: begin
          if (inBeat) begin
            for (int i = 0; i < 14; i++) begin
              if (cnt_q == 4'(i)) hdr_q[(13 - i) * 8 +: 8] <= s_axis_tdata;
            end
            if (s_axis_tlast) begin
              statRunt_q <= 1'b1;
              cnt_q      <= 4'd0;
            end else if (cnt_q == 4'd13) begin
              cnt_q <= 4'd0;
              if (hdrMatch) begin
                hdrValid_q <= 1'b1;
                state_q    <= HDR_OUT;
              end else begin
                statFiltered_q <= 1'b1;
                state_q        <= DROP;
              end
            end else begin
              cnt_q <= cnt_q + 4'd1;
            end
          end
        end
        HDR_OUT: begin
          if (m_eth_hdr_ready) begin
            hdrValid_q     <= 1'b0;
            statAccepted_q <= 1'b1;
            state_q        <= PAYLOAD;
          end
        end
        PAYLOAD: begin
          if (inBeat && s_axis_tlast) begin
            cnt_q   <= 4'd0;
            state_q <= HDR;
          end
        end
        DROP: begin
          if (inBeat && s_axis_tlast) state_q <= HDR;
        end
        default: state_q <= HDR;
      endcase
    end
  end

  assign m_eth_hdr_valid = hdrValid_q;
  assign m_eth_dest_mac  = hdr_q[111:64];
  assign m_eth_src_mac   = hdr_q[63:16];
  assign m_eth_type      = hdr_q[15:0];
  assign stat_accepted   = statAccepted_q;
  assign stat_filtered   = statFiltered_q;
  assign stat_runt       = statRunt_q;

endmodule

// File: tb/tb_eth_rx_hdr_filter.sv
// Directed bench for eth_rx_hdr_filter: two instances, one with default
// parameters and one with the EtherType filter enabled, sharing one driver.
module tb_eth_rx_hdr_filter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  sData;
  logic        sValid, sLast, sUser;
  logic        sel;
  logic        mReady, hdrReady;
  logic [47:0] localMac;
  logic        promisc;
  logic        stallEn;

  logic        aValidIn, bValidIn;
  logic        aTready, aHdrValid, aTvalid, aTlast, aTuser, aAcc, aFilt, aRunt;
  logic        bTready, bHdrValid, bTvalid, bTlast, bTuser, bAcc, bFilt, bRunt;
  logic [47:0] aDest, aSrc, bDest, bSrc;
  logic [15:0] aType, bType;
  logic [7:0]  aTdata, bTdata;

  logic        vTready, vHdrValid, vTvalid, vTlast, vTuser, vAcc, vFilt, vRunt;
  logic [47:0] vDest, vSrc;
  logic [15:0] vType;
  logic [7:0]  vTdata;

  int nChecks = 0;
  int nErrors = 0;

  int cyc, mBeats, hdrCount, nAcc, nFilt, nRunt, inBeats, stallCycles;
  int frameIdx, byte14Cyc, hdrRiseCyc;
  logic        prevHdrValid;
  logic [7:0]  outData[$];
  logic        outLast[$];
  logic        outUser[$];
  logic [47:0] gotDest, gotSrc;
  logic [15:0] gotType;

  logic [7:0]  frameQ[$];
  logic [7:0]  expPay[$];

  always #5 clk = ~clk;

  assign aValidIn = sValid & ~sel;
  assign bValidIn = sValid & sel;

  eth_rx_hdr_filter dutA (
    .logic_clk(clk), .logic_rst_n(rst_n),
    .s_axis_tdata(sData), .s_axis_tvalid(aValidIn), .s_axis_tready(aTready),
    .s_axis_tlast(sLast), .s_axis_tuser(sUser),
    .m_eth_hdr_valid(aHdrValid), .m_eth_hdr_ready(hdrReady),
    .m_eth_dest_mac(aDest), .m_eth_src_mac(aSrc), .m_eth_type(aType),
    .m_axis_tdata(aTdata), .m_axis_tvalid(aTvalid), .m_axis_tready(mReady),
    .m_axis_tlast(aTlast), .m_axis_tuser(aTuser),
    .local_mac(localMac), .promisc_en(promisc),
    .stat_accepted(aAcc), .stat_filtered(aFilt), .stat_runt(aRunt)
  );

  eth_rx_hdr_filter #(.ETYPE_FILTER_EN(1'b1)) dutB (
    .logic_clk(clk), .logic_rst_n(rst_n),
    .s_axis_tdata(sData), .s_axis_tvalid(bValidIn), .s_axis_tready(bTready),
    .s_axis_tlast(sLast), .s_axis_tuser(sUser),
    .m_eth_hdr_valid(bHdrValid), .m_eth_hdr_ready(hdrReady),
    .m_eth_dest_mac(bDest), .m_eth_src_mac(bSrc), .m_eth_type(bType),
    .m_axis_tdata(bTdata), .m_axis_tvalid(bTvalid), .m_axis_tready(mReady),
    .m_axis_tlast(bTlast), .m_axis_tuser(bTuser),
    .local_mac(localMac), .promisc_en(promisc),
    .stat_accepted(bAcc), .stat_filtered(bFilt), .stat_runt(bRunt)
  );

  // View of whichever instance is currently being driven.
  assign vTready   = sel ? bTready   : aTready;
  assign vHdrValid = sel ? bHdrValid : aHdrValid;
  assign vTvalid   = sel ? bTvalid   : aTvalid;
  assign vTlast    = sel ? bTlast    : aTlast;
  assign vTuser    = sel ? bTuser    : aTuser;
  assign vAcc      = sel ? bAcc      : aAcc;
  assign vFilt     = sel ? bFilt     : aFilt;
  assign vRunt     = sel ? bRunt     : aRunt;
  assign vDest     = sel ? bDest     : aDest;
  assign vSrc      = sel ? bSrc      : aSrc;
  assign vType     = sel ? bType     : aType;
  assign vTdata    = sel ? bTdata    : aTdata;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nErrors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  // Monitor: samples just before each rising edge, records transfers and stat pulses.
  initial begin
    cyc = 0;
    prevHdrValid = 1'b0;
    frameIdx = 0;
    forever begin
      @(negedge clk);
      #2;
      cyc++;
      if (!rst_n) begin
        frameIdx     = 0;
        prevHdrValid = 1'b0;
      end else begin
        if (vTvalid && mReady) begin
          mBeats++;
          outData.push_back(vTdata);
          outLast.push_back(vTlast);
          outUser.push_back(vTuser);
        end
        if (vHdrValid && hdrReady) begin
          hdrCount++;
          gotDest = vDest;
          gotSrc  = vSrc;
          gotType = vType;
        end
        if (vHdrValid && !prevHdrValid) hdrRiseCyc = cyc;
        prevHdrValid = vHdrValid;
        nAcc  += int'(vAcc);
        nFilt += int'(vFilt);
        nRunt += int'(vRunt);
        if (sValid && !vTready) stallCycles++;
        if (sValid && vTready) begin
          inBeats++;
          frameIdx++;
          if (frameIdx == 14) byte14Cyc = cyc;
          if (sLast) frameIdx = 0;
        end
      end
    end
  end

  // Random back-pressure on the header and payload handshakes when enabled.
  initial begin
    forever begin
      @(negedge clk);
      if (stallEn) begin
        mReady   = 1'($urandom_range(0, 1));
        hdrReady = 1'($urandom_range(0, 1));
      end
    end
  end

  task automatic clearMon();
    mBeats = 0; hdrCount = 0; nAcc = 0; nFilt = 0; nRunt = 0;
    inBeats = 0; stallCycles = 0; byte14Cyc = -100; hdrRiseCyc = 0;
    outData.delete(); outLast.delete(); outUser.delete();
  endtask

  task automatic buildFrame(input logic [47:0] dst, input logic [47:0] src,
                            input logic [15:0] typ, input int payLen, input logic [7:0] seed);
    frameQ.delete();
    expPay.delete();
    for (int i = 5; i >= 0; i--) frameQ.push_back(dst[i*8 +: 8]);
    for (int i = 5; i >= 0; i--) frameQ.push_back(src[i*8 +: 8]);
    frameQ.push_back(typ[15:8]);
    frameQ.push_back(typ[7:0]);
    for (int k = 0; k < payLen; k++) begin
      frameQ.push_back(seed + 8'(k));
      expPay.push_back(seed + 8'(k));
    end
  endtask

  // Drives frameQ byte by byte; stops early before index abortAt when abortAt >= 0.
  task automatic applyStimulus(input int abortAt, input logic lastUser);
    logic ok;
    logic accepted;
    for (int i = 0; i < frameQ.size(); i++) begin
      if (abortAt >= 0 && i == abortAt) return;
      @(negedge clk);
      sValid = 1'b1;
      sData  = frameQ[i];
      sLast  = (i == frameQ.size() - 1);
      sUser  = sLast & lastUser;
      accepted = 1'b0;
      for (int w = 0; w < 200 && !accepted; w++) begin
        #1;
        ok = vTready;
        @(posedge clk);
        if (ok) accepted = 1'b1;
        else @(negedge clk);
      end
      if (!accepted) begin
        checkOutput("drive_timeout", 64'(0), 64'(1));
        sValid = 1'b0;
        return;
      end
    end
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    sValid = 1'b0;
    sLast  = 1'b0;
    sUser  = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic checkPayload(input int n, input logic lastUser, input logic fullFrame);
    checkOutput("beat_count", 64'(outData.size()), 64'(n));
    for (int k = 0; k < n && k < outData.size(); k++) begin
      checkOutput("pay_data", 64'(outData[k]), 64'(expPay[k]));
      checkOutput("pay_last", 64'(outLast[k]), 64'(fullFrame && k == n - 1));
      checkOutput("pay_user", 64'(outUser[k]), 64'(fullFrame && lastUser && k == n - 1));
    end
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0; sValid = 1'b0; sData = 8'h00; sLast = 1'b0; sUser = 1'b0;
    sel = 1'b0; mReady = 1'b1; hdrReady = 1'b1; promisc = 1'b0; stallEn = 1'b0;
    localMac = 48'h02_00_00_00_00_01;
    clearMon();
    repeat (3) @(negedge clk);
    #1;
    checkOutput("rst_hdr_valid", 64'(aHdrValid), 64'(0));
    checkOutput("rst_dest", 64'(aDest), 64'(0));
    checkOutput("rst_type", 64'(aType), 64'(0));
    checkOutput("rst_stats", 64'({aAcc, aFilt, aRunt, aTvalid}), 64'(0));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] frame to local MAC");
    clearMon();
    buildFrame(localMac, 48'h0a_0b_0c_0d_0e_0f, 16'h0800, 46, 8'h10);
    applyStimulus(-1, 1'b0);
    idle(5);
    checkOutput("t1_hdr_count", 64'(hdrCount), 64'(1));
    checkOutput("t1_dest", 64'(gotDest), 64'(48'h02_00_00_00_00_01));
    checkOutput("t1_src", 64'(gotSrc), 64'(48'h0a_0b_0c_0d_0e_0f));
    checkOutput("t1_type", 64'(gotType), 64'(16'h0800));
    checkOutput("t1_hdr_latency", 64'(hdrRiseCyc - byte14Cyc), 64'(1));
    checkOutput("t1_acc", 64'(nAcc), 64'(1));
    checkOutput("t1_filt_runt", 64'(nFilt + nRunt), 64'(0));
    checkPayload(46, 1'b0, 1'b1);

    $display("[TB] frame to other MAC");
    clearMon();
    buildFrame(48'h02_00_00_00_00_02, 48'h0a_0b_0c_0d_0e_0f, 16'h0800, 46, 8'h40);
    applyStimulus(-1, 1'b0);
    idle(5);
    checkOutput("t2_hdr_count", 64'(hdrCount), 64'(0));
    checkOutput("t2_beats", 64'(mBeats), 64'(0));
    checkOutput("t2_filt", 64'(nFilt), 64'(1));
    checkOutput("t2_acc", 64'(nAcc), 64'(0));
    checkOutput("t2_in_beats", 64'(inBeats), 64'(60));
    checkOutput("t2_stalls", 64'(stallCycles), 64'(0));

    $display("[TB] broadcast, multicast, promiscuous");
    clearMon();
    buildFrame(48'hFF_FF_FF_FF_FF_FF, 48'h11_22_33_44_55_66, 16'h0806, 46, 8'h80);
    applyStimulus(-1, 1'b0);
    idle(5);
    checkOutput("t3_bc_acc", 64'(nAcc), 64'(1));
    checkOutput("t3_bc_dest", 64'(gotDest), 64'(48'hFF_FF_FF_FF_FF_FF));
    checkPayload(46, 1'b0, 1'b1);
    clearMon();
    buildFrame(48'h01_00_5e_00_00_01, 48'h11_22_33_44_55_66, 16'h0800, 46, 8'h90);
    applyStimulus(-1, 1'b0);
    idle(5);
    checkOutput("t3_mc_filt", 64'(nFilt), 64'(1));
    checkOutput("t3_mc_beats", 64'(mBeats), 64'(0));
    clearMon();
    promisc = 1'b1;
    applyStimulus(-1, 1'b0);
    idle(5);
    promisc = 1'b0;
    checkOutput("t3_pr_acc", 64'(nAcc), 64'(1));
    checkOutput("t3_pr_dest", 64'(gotDest), 64'(48'h01_00_5e_00_00_01));
    checkPayload(46, 1'b0, 1'b1);

    $display("[TB] runt frames");
    clearMon();
    buildFrame(localMac, 48'h11_22_33_44_55_66, 16'h0800, 0, 8'h00);
    while (frameQ.size() > 10) void'(frameQ.pop_back());
    applyStimulus(-1, 1'b0);
    buildFrame(localMac, 48'h77_88_99_aa_bb_cc, 16'h0800, 46, 8'h33);
    applyStimulus(-1, 1'b0);
    idle(5);
    checkOutput("t4_runt", 64'(nRunt), 64'(1));
    checkOutput("t4_hdr_count", 64'(hdrCount), 64'(1));
    checkOutput("t4_src", 64'(gotSrc), 64'(48'h77_88_99_aa_bb_cc));
    checkOutput("t4_acc", 64'(nAcc), 64'(1));
    checkPayload(46, 1'b0, 1'b1);
    clearMon();
    buildFrame(localMac, 48'h11_22_33_44_55_66, 16'h0800, 0, 8'h00);
    applyStimulus(-1, 1'b0);
    idle(5);
    checkOutput("t4_14b_runt", 64'(nRunt), 64'(1));
    checkOutput("t4_14b_hdr", 64'(hdrCount), 64'(0));
    clearMon();
    buildFrame(localMac, 48'h11_22_33_44_55_66, 16'h0800, 1, 8'h5a);
    applyStimulus(-1, 1'b0);
    idle(5);
    checkOutput("t4_15b_runt", 64'(nRunt), 64'(0));
    checkOutput("t4_15b_acc", 64'(nAcc), 64'(1));
    checkPayload(1, 1'b0, 1'b1);

    $display("[TB] EtherType filter instance");
    sel = 1'b1;
    clearMon();
    buildFrame(localMac, 48'h11_22_33_44_55_66, 16'h0806, 46, 8'h20);
    applyStimulus(-1, 1'b0);
    idle(5);
    checkOutput("t5_arp_filt", 64'(nFilt), 64'(1));
    checkOutput("t5_arp_hdr", 64'(hdrCount), 64'(0));
    clearMon();
    buildFrame(localMac, 48'h11_22_33_44_55_66, 16'h0800, 46, 8'h60);
    applyStimulus(-1, 1'b1);
    idle(5);
    checkOutput("t5_ip_acc", 64'(nAcc), 64'(1));
    checkPayload(46, 1'b1, 1'b1);
    sel = 1'b0;

    $display("[TB] stalls and mid-payload reset");
    stallEn = 1'b1;
    clearMon();
    buildFrame(localMac, 48'h21_22_23_24_25_26, 16'h0800, 20, 8'hc0);
    applyStimulus(-1, 1'b0);
    idle(8);
    checkOutput("t6_a_acc", 64'(nAcc), 64'(1));
    checkPayload(20, 1'b0, 1'b1);
    clearMon();
    buildFrame(localMac, 48'h31_32_33_34_35_36, 16'h0800, 30, 8'hd0);
    applyStimulus(20, 1'b0);
    stallEn = 1'b0;
    @(negedge clk);
    mReady   = 1'b0;
    hdrReady = 1'b1;
    rst_n    = 1'b0;
    sValid   = 1'b1;
    sData    = 8'hAA;
    sLast    = 1'b0;
    #1;
    checkOutput("t6_rst_hdr_valid", 64'(aHdrValid), 64'(0));
    checkOutput("t6_rst_tvalid", 64'(aTvalid), 64'(0));
    checkOutput("t6_rst_fields", 64'(aSrc), 64'(0));
    checkOutput("t6_rst_stats", 64'({aAcc, aFilt, aRunt}), 64'(0));
    checkOutput("t6_rst_in_hdr", 64'(aTready), 64'(1));
    checkPayload(6, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    sValid = 1'b0;
    rst_n  = 1'b1;
    mReady = 1'b1;
    repeat (2) @(negedge clk);
    clearMon();
    buildFrame(localMac, 48'h41_42_43_44_45_46, 16'h0800, 46, 8'he0);
    applyStimulus(-1, 1'b0);
    idle(5);
    checkOutput("t6_post_acc", 64'(nAcc), 64'(1));
    checkOutput("t6_post_src", 64'(gotSrc), 64'(48'h41_42_43_44_45_46));
    checkPayload(46, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
